// File: rtl/serial_rx_8_pkg.sv
// Shared types and constants for the 8-bit serial receiver.
package serial_rx_8_pkg;

   localparam int FRAME_BITS = 8;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_rx_8_bit_counter_4.sv
// Received-bit counter with a synchronous clear and an increment enable.
module bit_counter_4
   import serial_rx_8_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             Inc,
   output logic [CNT_W-1:0] Count
);

   always_ff @(posedge Clk) begin
      if (Reset || Clear)
         Count <= '0;
      else if (Inc)
         Count <= Count + CNT_W'(1);
   end

endmodule

// File: rtl/serial_rx_8.sv
// LSB-first serial-to-parallel receiver for one 8-bit frame per Start,
// holding the byte until Ack and flagging strobes that arrive meanwhile.
module serial_rx_8
   import serial_rx_8_pkg::*;
(
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Ser_In,
   input  logic                  Ser_En,
   input  logic                  Ack,
   output logic [FRAME_BITS-1:0] Data_Out,
   output logic                  Valid,
   output logic                  Busy,
   output logic                  Overrun
);

   state_t                 state, next_state;
   logic [FRAME_BITS-1:0]  shift;
   logic [CNT_W-1:0]       count;
   logic                   cnt_clear, cnt_inc;
   logic                   shift_clear, shift_load;
   logic                   complete, set_overrun, clear_valid;

   bit_counter_4 u_bit_counter (
      .Clk   (Clk),
      .Reset (Reset),
      .Clear (cnt_clear),
      .Inc   (cnt_inc),
      .Count (count)
   );

   always_comb begin
      next_state  = state;
      cnt_clear   = 1'b0;
      cnt_inc     = 1'b0;
      shift_clear = 1'b0;
      shift_load  = 1'b0;
      complete    = 1'b0;
      set_overrun = 1'b0;
      clear_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (Start) begin
               next_state  = RECV;
               cnt_clear   = 1'b1;
               shift_clear = 1'b1;
            end
         end
         RECV: begin
            if (Ser_En) begin
               cnt_inc    = 1'b1;
               shift_load = 1'b1;
               if (count == CNT_W'(FRAME_BITS - 1)) begin
                  complete   = 1'b1;
                  next_state = DONE;
               end
            end
         end
         DONE: begin
            // A strobe here has no frame to land in; it is dropped and flagged.
            set_overrun = Ser_En;
            if (Ack) begin
               clear_valid = 1'b1;
               if (Start) begin
                  next_state  = RECV;
                  cnt_clear   = 1'b1;
                  shift_clear = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         shift    <= '0;
         Data_Out <= '0;
         Valid    <= 1'b0;
         Overrun  <= 1'b0;
      end else begin
         state <= next_state;
         if (shift_clear)
            shift <= '0;
         else if (shift_load)
            shift <= {Ser_In, shift[FRAME_BITS-1:1]};
         // The final bit goes straight into the output, not via the shifter.
         if (complete)
            Data_Out <= {Ser_In, shift[FRAME_BITS-1:1]};
         if (complete)
            Valid <= 1'b1;
         else if (clear_valid)
            Valid <= 1'b0;
         if (set_overrun)
            Overrun <= 1'b1;
      end
   end

   assign Busy = (state == RECV);

endmodule

// File: tb/tb_serial_rx_8.sv
// Directed and randomized bench for serial_rx_8 against a queue-based frame model.
module tb_serial_rx_8;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Start = 1'b0;
   logic       Ser_In = 1'b0;
   logic       Ser_En = 1'b0;
   logic       Ack = 1'b0;
   logic [7:0] Data_Out;
   logic       Valid;
   logic       Busy;
   logic       Overrun;

   int checks = 0;
   int errors = 0;

   // reference model: a frame is a list of received bits, LSB first
   bit         m_rx;
   bit         m_bits[$];
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ovr;

   serial_rx_8 dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Start    (Start),
      .Ser_In   (Ser_In),
      .Ser_En   (Ser_En),
      .Ack      (Ack),
      .Data_Out (Data_Out),
      .Valid    (Valid),
      .Busy     (Busy),
      .Overrun  (Overrun)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model(input bit st, input bit si, input bit en, input bit ak, input bit rs);
      if (rs) begin
         m_rx = 0; m_bits.delete(); m_data = 8'h00; m_valid = 0; m_ovr = 0;
      end else if (m_rx) begin
         if (en) begin
            m_bits.push_back(si);
            if (m_bits.size() == 8) begin
               for (int i = 0; i < 8; i++) m_data[i] = m_bits[i];
               m_valid = 1;
               m_rx = 0;
            end
         end
      end else if (m_valid) begin
         if (en) m_ovr = 1;
         if (ak) begin
            m_valid = 0;
            if (st) begin m_rx = 1; m_bits.delete(); end
         end
      end else if (st) begin
         m_rx = 1; m_bits.delete();
      end
   endtask

   task automatic step(input bit st, input bit si, input bit en, input bit ak, input bit rs);
      Start = st; Ser_In = si; Ser_En = en; Ack = ak; Reset = rs;
      @(posedge Clk);
      model(st, si, en, ak, rs);
      #1;
      chk(Data_Out, m_data, "data");
      chk({7'd0, Valid}, {7'd0, m_valid}, "valid");
      chk({7'd0, Busy}, {7'd0, m_rx}, "busy");
      chk({7'd0, Overrun}, {7'd0, m_ovr}, "overrun");
   endtask

   task automatic send_frame(input logic [7:0] b, input int gap);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(0, b[i], 1, 0, 0);
         if (i < 7) for (int g = 0; g < gap; g++) step(0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      logic [7:0] b;
      // reset state
      step(0, 0, 0, 0, 1);
      chk(Data_Out, 8'h00, "reset_data");
      chk({6'd0, Valid, Overrun}, 8'h00, "reset_flags");
      step(0, 1, 1, 1, 0);               // strobe and Ack in IDLE: ignored
      chk({7'd0, Busy}, 8'h00, "idle_ignore");

      // A5 back-to-back
      send_frame(8'hA5, 0);
      chk(Data_Out, 8'hA5, "frame_a5");
      chk({6'd0, Valid, Busy}, 8'h02, "a5_valid_busy");
      step(0, 0, 0, 1, 0);

      // 3C with gaps between strobes
      send_frame(8'h3C, 2);
      chk(Data_Out, 8'h3C, "frame_3c");

      // held in DONE: strobes and Start ignored, overrun set
      step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0);
      chk(Data_Out, 8'h3C, "done_hold");
      chk({6'd0, Valid, Overrun}, 8'h03, "done_ovr");

      // Ack+Start together, then FF
      step(1, 0, 0, 1, 0);
      chk({6'd0, Valid, Busy}, 8'h01, "ack_start");
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
      chk(Data_Out, 8'hFF, "frame_ff");
      chk({7'd0, Overrun}, 8'h01, "ovr_sticky");
      step(0, 0, 0, 1, 0);

      // reset mid-frame, then strobes without Start
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
      step(1, 1, 1, 1, 1);
      chk({5'd0, Valid, Busy, Overrun}, 8'h00, "reset_mid");
      for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
      chk({7'd0, Valid}, 8'h00, "no_valid_after_reset");

      // Start re-asserted mid-frame
      b = 8'h81;
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         step(i == 4, b[i], 1, 0, 0);
         if (i == 3) step(1, 0, 0, 0, 0);
      end
      chk(Data_Out, 8'h81, "frame_81");
      step(0, 0, 0, 1, 0);

      // randomized traffic
      for (int n = 0; n < 600; n++)
         step($urandom_range(3) == 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
              $urandom_range(4) == 0, $urandom_range(99) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_rx_8.md
SERIAL_RX_8 -- requirements
Module: serial_rx_8

Interface
REQ-001: Clk  input  1  system clock; all state changes on posedge Clk.
REQ-002: Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-003: Start  input  1  request to begin receiving one 8-bit frame.
REQ-004: Ser_In  input  1  serial data bit; LSB of frame arrives first.
REQ-005: Ser_En  input  1  bit strobe; Ser_In is sampled only on edges where Ser_En=1.
REQ-006: Ack  input  1  consumer acknowledges the current Data_Out.
REQ-007: Data_Out  output  8  last completed frame, registered.
REQ-008: Valid  output  1  Data_Out holds an unacknowledged frame.
REQ-009: Busy  output  1  frame reception in progress (state RECV).
REQ-010: Overrun  output  1  sticky flag; a bit strobe arrived while a frame awaited Ack.

Function
REQ-011: The FSM SHALL have exactly three states: IDLE, RECV, DONE.
REQ-012: In IDLE with Start=1, the next state SHALL be RECV, with the internal shift register cleared to 8'h00 and the bit counter cleared to 0.
REQ-013: In IDLE, Ser_En SHALL be ignored.
REQ-014: In RECV, each edge with Ser_En=1 SHALL load shift = {Ser_In, shift[7:1]} and increment the counter by 1.
REQ-015: In RECV, edges with Ser_En=0 SHALL hold the shift register and counter.
REQ-016: On the edge accepting the 8th bit (counter 7->8), the assembled byte SHALL be written to Data_Out, Valid SHALL be set, and the state SHALL go to DONE.
REQ-017: Valid SHALL therefore be observed high one cycle after the 8th strobe is sampled; frame latency = 8 strobes + 1 cycle after Start.
REQ-018: Start in RECV SHALL be ignored; it neither restarts the frame nor changes the counter.
REQ-019: Busy SHALL equal 1 exactly when the state is RECV.
REQ-020: In DONE, Data_Out and Valid SHALL hold until Ack=1.
REQ-021: In DONE with Ack=1 and Start=0, Valid SHALL clear and the state SHALL return to IDLE.
REQ-022: In DONE with Ack=1 and Start=1 on the same edge, Valid SHALL clear and the state SHALL go directly to RECV, initialized as in REQ-012.
REQ-023: In DONE with Ack=0, Start SHALL be ignored.
REQ-024: In DONE, a strobe with Ser_En=1 SHALL be dropped and SHALL set Overrun; Overrun SHALL clear only on Reset.
REQ-025: Ack outside DONE SHALL have no effect.
REQ-026: Data_Out SHALL change only on the frame-completion edge (REQ-016) or on Reset.

Reset
REQ-027: Reset=1 SHALL override all other inputs on that edge.
REQ-028: Reset SHALL force state=IDLE, shift=8'h00, counter=0, Data_Out=8'h00, Valid=0, Busy=0, Overrun=0.
REQ-029: Reset during RECV SHALL discard the partial frame; no Valid pulse SHALL follow.

Structure
REQ-030: The shared package SHALL hold the state enum (IDLE, RECV, DONE) and the constant FRAME_BITS=8.
REQ-031: The bit counter SHALL be a separate sub-module, bit_counter_4: 4-bit, with synchronous Clear and Inc inputs and a Count output.
REQ-032: The shift register, output register and FSM SHALL reside in serial_rx_8.

Verification
REQ-033: Reset, Start, 8 strobes with LSB-first bits of 8'hA5 (1,0,1,0,0,1,0,1) -> Valid=1 and Data_Out=8'hA5 one cycle after the 8th strobe; Busy=0.
REQ-034: Frame 8'h3C with 2-cycle gaps (Ser_En=0) between strobes -> Data_Out=8'h3C; Busy high for the entire gap-extended window.
REQ-035: Hold in DONE with Ack=0, pulse Ser_En=1 twice and Start once -> Data_Out unchanged, Overrun=1, state stays DONE.
REQ-036: In DONE, Ack=1 and Start=1 together, then send 8'hFF -> Valid drops for the frame, then Valid=1 with Data_Out=8'hFF; Overrun unchanged.
REQ-037: Reset asserted after 5 strobes of a frame -> all outputs at reset values; 10 further strobes without Start -> Valid stays 0.
REQ-038: Start re-asserted at bit 4 of frame 8'h81 -> frame completes as 8'h81 after 8 total strobes, with no restart.
